router_ram_fifo_ctrl: RTL and testbench

Ingress FIFO controller for the router's 4x73 vendor RAM macro, which has a registered read with 2-cycle latency. It turns that macro into a valid/ready FIFO. A 3-entry register output buffer plus read-credit tracking hides the RAM read latency, so the FIFO sustains one word per cycle. The block sits between a router input port and the crossbar, and drives the RAM functional ports; BIST ports are tied off at the top level.

---
 rtl/router_fifo_pkg.sv | 11 +
 rtl/router_fifo_obuf.sv | 45 ++++
 rtl/router_ram_fifo_ctrl.sv | 87 ++++++++
 tb/tb_router_ram_fifo_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_fifo_pkg.sv
// Shared widths and types for the router ingress FIFO built on the 4x73 RAM macro.
// Pure declarations; no logic, no latency, no flow control.
// Consumers import with router_fifo_pkg::*.
package router_fifo_pkg;
    localparam int WORD_W   = 73;
    localparam int RAM_AW   = 2;
    localparam int OB_DEPTH = 3;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [RAM_AW-1:0] ram_ptr_t;
endpackage

// File: rtl/router_fifo_obuf.sv
// 3-entry register FIFO holding words returned from the RAM; entry 0 is always the head.
// Capture visible the cycle after the capture edge; out_data comes straight from a flop.
// No backpressure to the writer: the caller's read credits guarantee a free slot.
module router_fifo_obuf
    import router_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       capture_en,
    input  word_t      capture_data,
    input  logic       pop,
    output logic       out_valid,
    output word_t      out_data,
    output logic [1:0] count
);

    word_t      ent [OB_DEPTH];
    logic [1:0] wr_idx;

    // A pop shifts everything down one slot, so the new word lands one slot lower.
    assign wr_idx = count - {1'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < OB_DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            if (pop) begin
                for (int i = 0; i < OB_DEPTH - 1; i++) begin
                    ent[i] <= ent[i+1];
                end
            end
            if (capture_en) begin
                ent[wr_idx] <= capture_data;
            end
            count <= count + {1'b0, capture_en} - {1'b0, pop};
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_data  = ent[0];

endmodule

// File: rtl/router_ram_fifo_ctrl.sv
// Valid/ready FIFO around the 2-cycle-read RAM macro, 7 words deep, 1 word/cycle sustained.
// First word: accepted at edge 1, out_valid in cycle 4 (RAM write, issue, 2-cycle read, capture).
// in_ready is registered (RAM not full); reads are issued only against free output-buffer credits.
module router_ram_fifo_ctrl
    import router_fifo_pkg::*;
#(
    parameter int WIDTH     = router_fifo_pkg::WORD_W,
    parameter int RAM_DEPTH = 4,
    parameter int OB_DEPTH  = router_fifo_pkg::OB_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             ram_wr_en,
    output ram_ptr_t         ram_wr_addr,
    output logic [WIDTH-1:0] ram_wr_data,
    output logic             ram_rd_en,
    output ram_ptr_t         ram_rd_addr,
    input  logic [WIDTH-1:0] ram_rd_data,
    output logic [2:0]       occupancy
);

    ram_ptr_t   wr_ptr;
    ram_ptr_t   rd_ptr;
    logic [2:0] ram_cnt;
    logic [1:0] rd_pipe;
    logic [1:0] inflight;
    logic [1:0] ob_cnt;
    logic [2:0] credit_used;
    logic       push;
    logic       pop;
    logic       issue;

    assign in_ready = (ram_cnt < 3'(RAM_DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign inflight = {1'b0, rd_pipe[0]} + {1'b0, rd_pipe[1]};

    // A slot freed by this cycle's pop can be promised to a read issued this cycle.
    assign credit_used = {1'b0, ob_cnt} + {1'b0, inflight} - {2'b0, pop};
    // ram_cnt only counts words written on an earlier edge, so no same-edge write/read.
    assign issue       = (ram_cnt != 3'd0) && (credit_used < 3'(OB_DEPTH));

    assign ram_wr_en   = push;
    assign ram_wr_addr = wr_ptr;
    assign ram_wr_data = push ? in_data : '0;
    assign ram_rd_en   = issue;
    assign ram_rd_addr = rd_ptr;

    assign occupancy = ram_cnt + {1'b0, inflight} + {1'b0, ob_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            rd_pipe <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ram_cnt <= ram_cnt + {2'b0, push} - {2'b0, issue};
            rd_pipe <= {rd_pipe[0], issue};
        end
    end

    // rd_pipe[1] marks the cycle ram_rd_data carries the word issued two edges ago.
    router_fifo_obuf u_obuf (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture_en   (rd_pipe[1]),
        .capture_data (ram_rd_data),
        .pop          (pop),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .count        (ob_cnt)
    );

endmodule

// File: tb/tb_router_ram_fifo_ctrl.sv
// Bench for router_ram_fifo_ctrl with a behavioural RAM macro and a queue-based FIFO model.
module tb_router_ram_fifo_ctrl;
    import router_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    word_t      in_data;
    logic       out_valid;
    logic       out_ready;
    word_t      out_data;
    logic       ram_wr_en;
    ram_ptr_t   ram_wr_addr;
    word_t      ram_wr_data;
    logic       ram_rd_en;
    ram_ptr_t   ram_rd_addr;
    word_t      ram_rd_data = '0;
    logic [2:0] occupancy;

    always #5 clk = ~clk;

    router_ram_fifo_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .occupancy   (occupancy)
    );

    // Vendor macro: same-edge write/read returns old data, read data lands 2 edges after rd_en.
    word_t mem [4] = '{default: '0};
    word_t ram_s1  = '0;
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_s1 <= mem[ram_rd_addr];
        ram_rd_data <= ram_s1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words held = queue, RAM holds writes minus issued reads, reads land 2 cycles later.
    word_t      q[$];
    int         ram_words = 0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic [1:0] rd_h = 2'b00;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            ram_words = 0;
            wr_cnt    = 0;
            rd_cnt    = 0;
            rd_h      = 2'b00;
        end else begin
            int ob_est;
            chk("occupancy", occupancy, q.size());
            chk("in_ready", in_ready, ram_words < 4);
            chk("ram_wr_en", ram_wr_en, in_valid && (ram_words < 4));
            chk("valid_when_empty", out_valid && (q.size() == 0), 1'b0);
            ob_est = q.size() - ram_words - int'(rd_h[0]) - int'(rd_h[1]);
            chk("ob_bound", (ob_est >= 0) && (ob_est <= 3), 1'b1);
            if (ram_wr_en) begin
                chk("wr_addr", ram_wr_addr, wr_cnt % 4);
                chk("wr_data", ram_wr_data, in_data);
            end
            if (ram_rd_en) begin
                chk("rd_when_empty", ram_words > 0, 1'b1);
                chk("rd_addr", ram_rd_addr, rd_cnt % 4);
                chk("rd_wr_same_addr", ram_wr_en && (ram_wr_addr == ram_rd_addr), 1'b0);
            end
            if (out_valid && out_ready && q.size() > 0) begin
                chk("order", out_data, q[0]);
                void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(in_data);
            ram_words = ram_words + int'(ram_wr_en) - int'(ram_rd_en);
            wr_cnt    = wr_cnt + int'(ram_wr_en);
            rd_cnt    = rd_cnt + int'(ram_rd_en);
            rd_h      = {rd_h[0], ram_rd_en};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input word_t d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("push_accept", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain_all(input string name);
        int t = 0;
        out_ready = 1'b1;
        while (occupancy != 3'd0 && t < 100) begin
            step();
            t++;
        end
        chk(name, occupancy, 3'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt, pops, stalls, first, last, acc, exp_w, t;
        logic [95:0] r;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_occupancy", occupancy, 3'd0);
        chk("rst_wr_en", ram_wr_en, 1'b0);
        chk("rst_rd_en", ram_rd_en, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_rd_addr", ram_rd_addr, 2'd0);
        chk("rst_wr_addr", ram_wr_addr, 2'd0);

        // Single word: out_valid exactly in cycle 4
        step();
        in_valid = 1'b1;
        in_data  = 73'h1_2345_6789_ABCD_EF01;
        @(negedge clk);
        chk("single_accept", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        in_data  = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("first_word_valid", out_valid, c == 4);
            if (c == 1) chk("first_word_rd_en", ram_rd_en, 1'b1);
            if (c != 4) step();
        end
        chk("first_word_data", out_data, 73'h1_2345_6789_ABCD_EF01);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("single_occ_after_pop", occupancy, 3'd0);

        // Fill to 7 with out_ready low
        step();
        for (int w = 1; w <= 7; w++) push_word(w);
        @(negedge clk);
        chk("fill_in_ready", in_ready, 1'b0);
        chk("fill_occ", occupancy, 3'd7);
        repeat (4) step();
        @(negedge clk);
        chk("fill_hold_occ", occupancy, 3'd7);

        // Drain: first issue in the pop cycle, in_ready rises one cycle later
        step();
        out_ready = 1'b1;
        exp_w = 1;
        for (int c = 0; c < 40 && exp_w <= 7; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("release_rd_en", ram_rd_en, 1'b1);
                chk("release_in_ready_same", in_ready, 1'b0);
            end
            if (c == 1) chk("release_in_ready_next", in_ready, 1'b1);
            if (out_valid && out_ready) begin
                chk("drain_word", out_data, exp_w);
                exp_w++;
            end
            step();
        end
        chk("drain_count", exp_w, 8);
        drain_all("drain_empty");
        @(negedge clk);
        chk("drain_in_ready", in_ready, 1'b1);

        // Streaming 0..99
        out_ready = 1'b1;
        nxt = 0; pops = 0; stalls = 0; first = -1; last = -1;
        for (int c = 0; c < 300 && pops < 100; c++) begin
            step();
            in_valid = (nxt < 100);
            in_data  = nxt;
            @(negedge clk);
            if (in_valid && !in_ready) stalls++;
            if (in_valid && in_ready) nxt++;
            if (out_valid && out_ready) begin
                chk("stream_word", out_data, pops);
                if (first < 0) first = c;
                last = c;
                pops++;
            end
        end
        step();
        in_valid = 1'b0;
        chk("stream_stalls", stalls, 0);
        chk("stream_pops", pops, 100);
        chk("stream_first_cycle", first, 4);
        chk("stream_span", last - first, 99);
        drain_all("stream_empty");

        // Random traffic, 10k words, alternating backpressure phases
        acc = 0;
        for (int c = 0; c < 60000 && acc < 10000; c++) begin
            step();
            r = {$urandom, $urandom, $urandom};
            in_valid  = ($urandom_range(0, 99) < 70) && (acc < 10000);
            in_data   = r[72:0];
            out_ready = $urandom_range(0, 99) < (((c / 2000) % 2) ? 30 : 85);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
        end
        step();
        in_valid = 1'b0;
        chk("rand_accepted", acc, 10000);
        drain_all("rand_empty");

        // Reset mid-stream with 5 words held and a read in flight
        step();
        for (int w = 0; w < 5; w++) push_word(73'h100 + w);
        chk("pre_reset_occ", occupancy, 3'd5);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_reset_out_valid", out_valid, 1'b0);
            chk("post_reset_occ", occupancy, 3'd0);
            step();
        end
        push_word(73'hAA);
        out_ready = 1'b1;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("post_reset_valid", out_valid, 1'b1);
        chk("post_reset_first", out_data, 73'hAA);
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_reset_empty", occupancy, 3'd0);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
